// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Widths here are the defaults of the arbiter's ADDR_W / DATA_W.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;
  localparam int unsigned MEM_ARB_STRB_W = MEM_ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_e;

  typedef struct packed {
    logic                      we;
    logic [MEM_ARB_ADDR_W-1:0] addr;
    logic [MEM_ARB_DATA_W-1:0] wdata;
    logic [MEM_ARB_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants made while a fetch waits; raises force_o at STARVE_MAX.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_grant_i,
  input  logic if_grant_i,
  input  logic if_pend_i,
  output logic force_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating streak of data wins over a waiting fetch
  always_comb begin
    cnt_d = cnt_q;
    if (if_grant_i) begin
      cnt_d = '0;
    end else if (d_grant_i) begin
      if (!if_pend_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and data (load/store).
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W     = MEM_ARB_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_e  state_q;
  arb_owner_e  owner_q;
  mem_req_t    req_q;
  logic        m_req_valid_q;
  logic        if_rsp_valid_q;
  logic        d_rsp_valid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic force_if;
  logic take_if;
  logic take_d;
  logic grant_if;
  logic grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_grant_i  (grant_d),
    .if_grant_i (grant_if),
    .if_pend_i  (if_req_valid),
    .force_o    (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  assign take_if = if_req_valid & (~d_req_valid | force_if);
  assign take_d  = d_req_valid & ~take_if;

  // IDLE arbitration: data is the older instruction and normally wins
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (reset_n && state_q == IDLE) begin
      unique case (1'b1)
        take_d:  grant_d  = 1'b1;
        take_if: grant_if = 1'b1;
        default: ;
      endcase
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // Request capture, memory handshake and response routing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      req_q          <= '0;
      m_req_valid_q  <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            req_q <= '{we:    d_req_we,
                       addr:  d_req_addr,
                       wdata: d_req_wdata,
                       wstrb: d_req_wstrb};
            owner_q       <= OWN_D;
            m_req_valid_q <= 1'b1;
            state_q       <= REQ;
          end else if (grant_if) begin
            req_q <= '{we:    1'b0,
                       addr:  if_req_addr,
                       wdata: '0,
                       wstrb: '0};
            owner_q       <= OWN_IF;
            m_req_valid_q <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (m_req_ready) begin
            m_req_valid_q <= 1'b0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (m_rsp_valid) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            if (owner_q == OWN_IF) begin
              if_rsp_valid_q <= 1'b1;
              if_rdata_q     <= m_rdata;
            end else begin
              d_rsp_valid_q <= 1'b1;
              d_rdata_q     <= req_q.we ? '0 : m_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req_valid  = m_req_valid_q;
  assign m_we         = req_q.we;
  assign m_addr       = req_q.addr;
  assign m_wdata      = req_q.wdata;
  assign m_wstrb      = req_q.wstrb;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_rdata = if_rdata_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_rdata  = d_rdata_q;

  // A pending request must stay put until it is accepted
  a_if_hold: assert property (@(posedge clk) disable iff (!reset_n)
    if_req_valid && !if_req_ready |=>
      if_req_valid && $stable(if_req_addr));

  a_d_hold: assert property (@(posedge clk) disable iff (!reset_n)
    d_req_valid && !d_req_ready |=>
      d_req_valid && $stable({d_req_we, d_req_addr,
                              d_req_wdata, d_req_wstrb}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model.
// Builds with or without MEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_rsp_valid;
  logic [31:0] m_rdata;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_rdata (if_rsp_rdata),
    .d_req_valid  (d_req_valid),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_wstrb  (d_req_wstrb),
    .d_req_ready  (d_req_ready),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_rdata  (d_rsp_rdata),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rsp_valid  (m_rsp_valid),
    .m_rdata      (m_rdata)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int cyc;

  int unsigned if_rate, d_rate, rdy_rate, stray_rate, dly_max;
  int  dly_fix;
  bit  if_auto, d_auto, stray_once;
  bit  if_want, d_want, d_want_we;
  logic [31:0] if_want_addr, d_want_addr, d_want_wdata;
  logic [3:0]  d_want_wstrb;
  bit  if_acc, d_acc;

  bit  busy, sent, own_d;
  int  acc_cyc, pulse_cyc, starve;
  logic [68:0] exp_mreq;
  logic [31:0] exp_rdata;
  int  grants[$];

  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit  rsp_pend;
  int  rsp_cnt;
  logic [31:0] rsp_data;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] seed_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] wd,
                                        logic [3:0]  st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dev_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  task automatic step();
    bit exp_if, exp_d, mv_exp;
    @(negedge clk);
    cyc++;
    if (if_acc) begin if_req_valid = 1'b0; if_acc = 1'b0; end
    if (d_acc)  begin d_req_valid  = 1'b0; d_acc  = 1'b0; end
    if (!if_req_valid &&
        (if_want || (if_auto && $urandom_range(99) < if_rate))) begin
      if_req_valid = 1'b1;
      if_req_addr  = if_want ? if_want_addr
                   : {26'd0, 4'($urandom_range(15)), 2'b00};
      if_want = 1'b0;
    end
    if (!d_req_valid &&
        (d_want || (d_auto && $urandom_range(99) < d_rate))) begin
      d_req_valid = 1'b1;
      if (d_want) begin
        d_req_we    = d_want_we;
        d_req_addr  = d_want_addr;
        d_req_wdata = d_want_wdata;
        d_req_wstrb = d_want_wstrb;
      end else begin
        d_req_we    = 1'($urandom_range(1));
        d_req_addr  = {26'd0, 4'($urandom_range(15)), 2'b00};
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom);
      end
      d_want = 1'b0;
    end
    m_req_ready = ($urandom_range(99) < rdy_rate);
    m_rsp_valid = 1'b0;
    m_rdata     = $urandom;
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        m_rsp_valid = 1'b1;
        m_rdata     = rsp_data;
        rsp_pend    = 1'b0;
        pulse_cyc   = cyc + 1;
      end else begin
        rsp_cnt--;
      end
    end else if (stray_once || $urandom_range(99) < stray_rate) begin
      m_rsp_valid = 1'b1;
      stray_once  = 1'b0;
    end
    #1;
    if (if_rsp_valid || d_rsp_valid) begin
      chk("rsp_owner", {if_rsp_valid, d_rsp_valid},
          busy ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      chk("rsp_cycle", cyc, pulse_cyc);
      chk("rsp_data", own_d ? d_rsp_rdata : if_rsp_rdata, exp_rdata);
      busy = 1'b0;
      pulse_cyc = -1;
    end else if (busy && pulse_cyc == cyc) begin
      chk("rsp_missing", 1'b0, 1'b1);
      busy = 1'b0;
    end else if (busy && cyc - acc_cyc > 200) begin
      chk("rsp_timeout", 1'b0, 1'b1);
      busy = 1'b0;
    end
    mv_exp = busy && !sent && cyc > acc_cyc;
    chk("m_req_valid", m_req_valid, mv_exp);
    if (mv_exp) begin
      chk("m_req_fields", {m_we, m_addr, m_wdata, m_wstrb}, exp_mreq);
      if (m_req_ready) sent = 1'b1;
    end
    if (m_req_valid && m_req_ready && !rsp_pend) begin
      if (m_we) begin
        mem[m_addr] = merge(dev_rd(m_addr), m_wdata, m_wstrb);
        rsp_data    = $urandom;
      end else begin
        rsp_data = dev_rd(m_addr);
      end
      rsp_pend = 1'b1;
      rsp_cnt  = (dly_fix >= 0) ? dly_fix : int'($urandom_range(dly_max));
    end
    exp_if = 1'b0;
    exp_d  = 1'b0;
    if (!busy) begin
      if (if_req_valid &&
          (!d_req_valid || (GUARD && starve >= STARVE_MAX)))
        exp_if = 1'b1;
      else if (d_req_valid)
        exp_d = 1'b1;
    end
    chk("if_req_ready", if_req_ready, exp_if);
    chk("d_req_ready", d_req_ready, exp_d);
    if (if_req_ready) if_acc = 1'b1;
    if (d_req_ready)  d_acc  = 1'b1;
    if (exp_if || exp_d) begin
      busy = 1'b1; sent = 1'b0; own_d = exp_d;
      acc_cyc = cyc; pulse_cyc = -1;
      grants.push_back(int'(exp_d));
      if (exp_d) begin
        exp_mreq = {d_req_we, d_req_addr, d_req_wdata, d_req_wstrb};
        if (d_req_we) begin
          ref_mem[d_req_addr] = merge(ref_rd(d_req_addr),
                                      d_req_wdata, d_req_wstrb);
          exp_rdata = '0;
        end else begin
          exp_rdata = ref_rd(d_req_addr);
        end
        if (!if_req_valid) starve = 0;
        else if (starve < STARVE_MAX) starve++;
      end else begin
        exp_mreq  = {1'b0, if_req_addr, 32'd0, 4'd0};
        exp_rdata = ref_rd(if_req_addr);
        starve    = 0;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset_n = 1'b0;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    m_req_ready = 1'b0;  m_rsp_valid = 1'b0;
    if_acc = 1'b0; d_acc = 1'b0; if_want = 1'b0; d_want = 1'b0;
    busy = 1'b0; sent = 1'b0; rsp_pend = 1'b0;
    pulse_cyc = -1; starve = 0;
    mem.delete(); ref_mem.delete();
    #1;
    chk("rst_ctl", {if_req_ready, if_rsp_valid, d_req_ready,
                    d_rsp_valid, m_req_valid, m_we, m_wstrb}, '0);
    chk("rst_data", {if_rsp_rdata, d_rsp_rdata, m_addr}, '0);
    chk("rst_wdata", m_wdata, '0);
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int t0, cnt;
  int exp_g[6];

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    reset_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0;
    d_req_wdata = '0; d_req_wstrb = '0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rdata = '0;
    if_auto = 1'b0; d_auto = 1'b0; stray_once = 1'b0;
    if_rate = 0; d_rate = 0; rdy_rate = 100; stray_rate = 0;
    dly_max = 0; dly_fix = 0;
    if_want = 1'b0; d_want = 1'b0; d_want_we = 1'b0;
    if_want_addr = '0; d_want_addr = '0;
    d_want_wdata = '0; d_want_wstrb = '0;
    do_reset(2);

    // fetch only, zero-wait memory
    mem[32'h10] = 32'h13; ref_mem[32'h10] = 32'h13;
    if_want = 1'b1; if_want_addr = 32'h10;
    step(); t0 = cyc;
    chk("t1_if_ready", if_req_ready, 1'b1);
    step();
    chk("t1_m_req_valid", m_req_valid, 1'b1);
    step(); step();
    chk("t1_if_rsp", {if_rsp_valid, if_rsp_rdata}, {1'b1, 32'h13});
    chk("t1_latency", cyc - t0, 3);
    repeat (3) step();

    // simultaneous store and fetch
    d_want = 1'b1; d_want_we = 1'b1; d_want_addr = 32'h100;
    d_want_wdata = 32'hDEADBEEF; d_want_wstrb = 4'hF;
    if_want = 1'b1; if_want_addr = 32'h20;
    step();
    chk("t2_d_first", {if_req_ready, d_req_ready}, 2'b01);
    step();
    chk("t2_m_store", {m_req_valid, m_we, m_addr}, {2'b11, 32'h100});
    step(); step();
    chk("t2_d_rsp", {d_rsp_valid, if_req_ready, d_rsp_rdata},
        {2'b11, 32'h0});
    repeat (3) step();
    chk("t2_if_rsp", {if_rsp_valid, if_rsp_rdata},
        {1'b1, seed_word(32'h20)});
    d_want = 1'b1; d_want_we = 1'b0; d_want_addr = 32'h100;
    repeat (4) step();
    chk("t2_load_back", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'hDEADBEEF});
    repeat (2) step();

    // memory stalls the request for five cycles
    rdy_rate = 0;
    if_want = 1'b1; if_want_addr = 32'h40;
    step();
    d_want = 1'b1; d_want_we = 1'b0; d_want_addr = 32'h44;
    cnt = 0;
    repeat (5) begin step(); cnt += int'(m_req_valid); end
    chk("t3_hold_cycles", cnt, 5);
    rdy_rate = 100;
    repeat (3) step();
    chk("t3_if_rsp", if_rsp_valid, 1'b1);
    repeat (6) step();

    // reset while a load waits for its response
    dly_fix = 3;
    d_want = 1'b1; d_want_we = 1'b0; d_want_addr = 32'h104;
    repeat (3) step();
    do_reset(2);
    dly_fix = 0;
    cnt = 0;
    repeat (5) begin step(); cnt += int'(d_rsp_valid); end
    chk("t4_no_rsp", cnt, 0);
    if_want = 1'b1; if_want_addr = 32'h44;
    repeat (4) step();
    chk("t4_fresh_fetch", if_rsp_valid, 1'b1);
    repeat (2) step();

    // both requesters saturated
    for (int i = 0; i < 6; i++) exp_g[i] = (GUARD && i == 4) ? 0 : 1;
    grants.delete();
    if_auto = 1'b1; d_auto = 1'b1; if_rate = 100; d_rate = 100;
    repeat (40) step();
    if_auto = 1'b0; d_auto = 1'b0;
    chk("t5_grant_count", grants.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("t5_grant", grants[i], exp_g[i]);
    repeat (30) step();

    // stray memory response while idle
    stray_once = 1'b1;
    step(); step();
    chk("t6_no_pulse", {if_rsp_valid, d_rsp_valid}, 2'b00);
    if_want = 1'b1; if_want_addr = 32'h48;
    step();
    chk("t6_idle_accept", if_req_ready, 1'b1);
    repeat (4) step();

    // random traffic with stalls, waits and strays
    if_auto = 1'b1; d_auto = 1'b1; if_rate = 40; d_rate = 50;
    rdy_rate = 60; dly_fix = -1; dly_max = 3; stray_rate = 5;
    repeat (700) step();
    do_reset(2);
    repeat (800) step();
    if_auto = 1'b0; d_auto = 1'b0; rdy_rate = 100; stray_rate = 0;
    repeat (40) step();
    chk("drain_idle", {busy, if_req_valid, d_req_valid}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
